// File: rtl/gmii_tx_arbiter.sv
// rtl/gmii_tx_arbiter.sv - round-robin N-requester packet arbiter framing bytes onto GMII
// Optional FCS generation is enabled by defining GMII_TX_ARBITER_CRC_EN.
module gmii_tx_arbiter #(
    parameter int N          = 2,
    parameter int IFG_CYCLES = 12
) (
    input  logic           rx_clk,
    input  logic           reset,
    input  logic [N-1:0]   p_srdy,
    input  logic [8*N-1:0] p_data,
    input  logic [N-1:0]   p_eop,
    output logic [N-1:0]   p_drdy,
    output logic [7:0]     rxd,
    output logic           rx_dv,
    output logic           rx_er,
    output logic [N-1:0]   grant,
    output logic           pkt_done
);
    localparam int         OW       = $clog2(N);
    localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
`ifdef GMII_TX_ARBITER_CRC_EN
        S_FCS,
`endif
        S_IFG
    } state_t;

    state_t        state_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] ptr_q;
    logic [7:0]    cnt_q;

    logic          pick_valid_d;
    logic [OW-1:0] pick_idx_d;
    logic [N-1:0]  owner_oh;
    logic          own_srdy;
    logic          own_eop;
    logic [7:0]    own_data;

`ifdef GMII_TX_ARBITER_CRC_EN
    logic [31:0] crc_q;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction
`endif

    // Round-robin search from ptr_q+1; the smallest distance k is assigned last and wins.
    always_comb begin
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if ((i == ((int'(ptr_q) + k) % N)) && p_srdy[i]) begin
                    pick_valid_d = 1'b1;
                    pick_idx_d   = OW'(i);
                end
            end
        end
    end

    always_comb begin
        own_srdy = 1'b0;
        own_eop  = 1'b0;
        own_data = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                own_srdy = p_srdy[i];
                own_eop  = p_eop[i];
                own_data = p_data[8*i +: 8];
            end
        end
    end

    assign owner_oh = {{(N-1){1'b0}}, 1'b1} << owner_q;
    assign grant    = ((state_q != S_IDLE) && (state_q != S_IFG)) ? owner_oh : '0;
    // Gated by reset so a frame abandoned by reset never consumes another byte.
    assign p_drdy   = ((state_q == S_DATA) && !reset) ? owner_oh : '0;

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            ptr_q    <= OW'(N - 1);
            cnt_q    <= 8'h00;
            rxd      <= 8'h00;
            rx_dv    <= 1'b0;
            rx_er    <= 1'b0;
            pkt_done <= 1'b0;
`ifdef GMII_TX_ARBITER_CRC_EN
            crc_q    <= 32'hFFFFFFFF;
`endif
        end else begin
            rxd      <= 8'h00;
            rx_dv    <= 1'b0;
            rx_er    <= 1'b0;
            pkt_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid_d) begin
                        owner_q <= pick_idx_d;
                        ptr_q   <= pick_idx_d;
                        cnt_q   <= 8'h00;
                        state_q <= S_PRE;
                    end
                end
                S_PRE: begin
                    rxd   <= 8'h55;
                    rx_dv <= 1'b1;
                    if (cnt_q == 8'd6) begin
                        cnt_q   <= 8'h00;
                        state_q <= S_SFD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SFD: begin
                    rxd     <= 8'hD5;
                    rx_dv   <= 1'b1;
`ifdef GMII_TX_ARBITER_CRC_EN
                    crc_q   <= 32'hFFFFFFFF;
`endif
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    rx_dv <= 1'b1;
                    if (own_srdy) begin
                        rxd <= own_data;
`ifdef GMII_TX_ARBITER_CRC_EN
                        crc_q <= crc32_byte(crc_q, own_data);
                        if (own_eop) begin
                            cnt_q   <= 8'h00;
                            state_q <= S_FCS;
                        end
`else
                        if (own_eop) begin
                            pkt_done <= 1'b1;
                            cnt_q    <= 8'h00;
                            state_q  <= S_IFG;
                        end
`endif
                    end else begin
                        rx_er <= 1'b1;
                    end
                end
`ifdef GMII_TX_ARBITER_CRC_EN
                S_FCS: begin
                    // Shift the register down so the next FCS byte is always in bits [7:0].
                    rxd   <= ~crc_q[7:0];
                    rx_dv <= 1'b1;
                    crc_q <= {8'h00, crc_q[31:8]};
                    if (cnt_q == 8'd3) begin
                        pkt_done <= 1'b1;
                        cnt_q    <= 8'h00;
                        state_q  <= S_IFG;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
`endif
                S_IFG: begin
                    // The last gap cycle doubles as the arbitration cycle so the wire gap is exactly IFG_CYCLES.
                    if (cnt_q == IFG_LAST) begin
                        cnt_q <= 8'h00;
                        if (pick_valid_d) begin
                            owner_q <= pick_idx_d;
                            ptr_q   <= pick_idx_d;
                            state_q <= S_PRE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb/tb_gmii_tx_arbiter.sv - randomized self-checking bench for gmii_tx_arbiter
// Expected wire frames are built from packet lists; CRC expectations follow GMII_TX_ARBITER_CRC_EN.
module tb_gmii_tx_arbiter;
    localparam int N    = 3;
    localparam int IFG  = 5;
    localparam int NPK  = 10;
    localparam int MAXB = 16;
    localparam int NT   = N * NPK + 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   p_srdy;
    logic [8*N-1:0] p_data;
    logic [N-1:0]   p_eop;
    logic [N-1:0]   p_drdy;
    logic [7:0]     rxd;
    logic           rx_dv;
    logic           rx_er;
    logic [N-1:0]   grant;
    logic           pkt_done;

    always #5 clk = ~clk;

    gmii_tx_arbiter #(.N(N), .IFG_CYCLES(IFG)) dut (
        .rx_clk   (clk),
        .reset    (reset),
        .p_srdy   (p_srdy),
        .p_data   (p_data),
        .p_eop    (p_eop),
        .p_drdy   (p_drdy),
        .rxd      (rxd),
        .rx_dv    (rx_dv),
        .rx_er    (rx_er),
        .grant    (grant),
        .pkt_done (pkt_done)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] pb [NT][MAXB];
    int         pg [NT][MAXB];
    int         plen [NT];
    int         dq [N][$];
    int         mq [N][$];
    int         cb [N];
    int         cg [N];

    logic [7:0] exp_d [$];
    logic       exp_e [$];
    int         in_frame, seen_frame, gap_chk, gap_cnt, wi, owner, last_rr, frames;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef GMII_TX_ARBITER_CRC_EN
    function automatic logic [31:0] ref_crc(input int id);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int j = 0; j < plen[id]; j++) begin
            c = c ^ {24'h000000, pb[id][j]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction
`endif

    task automatic build(input int id);
        exp_d.delete();
        exp_e.delete();
        for (int k = 0; k < 7; k++) begin exp_d.push_back(8'h55); exp_e.push_back(1'b0); end
        exp_d.push_back(8'hD5); exp_e.push_back(1'b0);
        for (int j = 0; j < plen[id]; j++) begin
            for (int g = 0; g < pg[id][j]; g++) begin exp_d.push_back(8'h00); exp_e.push_back(1'b1); end
            exp_d.push_back(pb[id][j]); exp_e.push_back(1'b0);
        end
`ifdef GMII_TX_ARBITER_CRC_EN
        begin
            logic [31:0] f;
            f = ref_crc(id);
            for (int k = 0; k < 4; k++) begin exp_d.push_back(f[8*k +: 8]); exp_e.push_back(1'b0); end
        end
`endif
    endtask

    task automatic monitor();
        int own, i, last, pend;
        if (rx_dv) begin
            if (!in_frame) begin
                own = -1;
                for (int k = 1; k <= N; k++) begin
                    i = (last_rr + k) % N;
                    if (own < 0 && mq[i].size() > 0) own = i;
                end
                tests++;
                assert (own >= 0) else begin
                    fails++;
                    $error("FAIL unexpected_frame: observed rx_dv 1 expected no frame");
                end
                if (own >= 0) begin
                    build(mq[own].pop_front());
                    if (gap_chk) chk("ifg_gap", gap_cnt, IFG);
                    last_rr  = own;
                    owner    = own;
                    in_frame = 1;
                    wi       = 0;
                end
            end
            if (in_frame) begin
                last = exp_d.size() - 1;
                chk("rxd", rxd, exp_d[wi]);
                chk("rx_er", rx_er, exp_e[wi]);
                chk("pkt_done", pkt_done, (wi == last));
                chk("grant", grant, (wi == last) ? 0 : (1 << owner));
                wi++;
                if (wi > last) begin
                    in_frame   = 0;
                    seen_frame = 1;
                    gap_cnt    = 0;
                    frames++;
                    pend = 0;
                    for (int r = 0; r < N; r++) if (mq[r].size() > 0) pend = 1;
                    gap_chk = pend;
                end
            end
        end else begin
            if (in_frame) begin
                chk("frame_len", wi, exp_d.size());
                in_frame = 0;
                gap_chk  = 0;
            end
            chk("idle_out", {rxd, rx_er, pkt_done}, 0);
            gap_cnt++;
        end
    endtask

    task automatic drive();
        int id;
        logic [N-1:0]   s, e;
        logic [8*N-1:0] d;
        s = '0; e = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0 && cg[i] == 0) begin
                id = dq[i][0];
                s[i] = 1'b1;
                e[i] = (cb[i] == plen[id] - 1);
                d[8*i +: 8] = pb[id][cb[i]];
            end else begin
                d[8*i +: 8] = 8'($urandom);
            end
        end
        p_srdy = s; p_eop = e; p_data = d;
    endtask

    task automatic handshake();
        int id;
        chk("drdy_owner", (p_drdy == '0) || (p_drdy == grant), 1);
        for (int i = 0; i < N; i++) begin
            if (p_drdy[i]) begin
                if (p_srdy[i]) begin
                    id = dq[i][0];
                    cb[i]++;
                    if (cb[i] == plen[id]) begin
                        void'(dq[i].pop_front());
                        cb[i] = 0;
                        cg[i] = 0;
                    end else begin
                        cg[i] = pg[id][cb[i]];
                    end
                end else if (cg[i] > 0) begin
                    cg[i]--;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        drive();
        #1;
        handshake();
    endtask

    task automatic set_pkt(input int id, input int len);
        plen[id] = len;
        for (int j = 0; j < MAXB; j++) begin
            pb[id][j] = 8'($urandom);
            pg[id][j] = 0;
        end
    endtask

    task automatic load(input int r, input int id);
        dq[r].push_back(id);
        mq[r].push_back(id);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc, id, base, target;
        string s;
        reset = 1'b1; p_srdy = '0; p_data = '0; p_eop = '0;
        in_frame = 0; seen_frame = 0; gap_chk = 0; gap_cnt = 0; wi = 0; owner = 0;
        last_rr = N - 1; frames = 0;
        for (int i = 0; i < N; i++) begin cb[i] = 0; cg[i] = 0; end

        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < NPK; k++) begin
                id = r * NPK + k;
                set_pkt(id, $urandom_range(1, 12));
                for (int j = 1; j < MAXB; j++)
                    if ($urandom_range(0, 4) == 0) pg[id][j] = $urandom_range(1, 2);
            end
        end
        set_pkt(0, 4);
        for (int j = 0; j < 4; j++) pb[0][j] = 8'(j + 1);
        set_pkt(1, 6);
        pg[1][3] = 2;
        set_pkt(NPK, 1);
        pb[NPK][0] = 8'hA5;
        s = "123456789";
        set_pkt(2 * NPK, 9);
        for (int j = 0; j < 9; j++) pb[2 * NPK][j] = s[j];

        repeat (3) @(negedge clk);
        chk("rst_rxd", rxd, 8'h00);
        chk("rst_dv", rx_dv, 0);
        chk("rst_er", rx_er, 0);
        chk("rst_done", pkt_done, 0);
        chk("rst_grant", grant, 0);
        chk("rst_drdy", p_drdy, 0);
        reset = 1'b0;
        repeat (4) step();
        chk("idle_grant", grant, 0);

        for (int r = 0; r < N; r++)
            for (int k = 0; k < NPK; k++) load(r, r * NPK + k);
        cyc = 0;
        while (frames < N * NPK && cyc < 20000) begin step(); cyc++; end
        chk("all_frames", frames, N * NPK);
        repeat (IFG + 4) step();

        // Mid-frame reset on requester 0 leaves the pointer on 0 unless reset restores it.
        base = N * NPK;
        set_pkt(base, 8);
        load(0, base);
        cyc = 0;
        while (cb[0] != 2 && cyc < 200) begin step(); cyc++; end
        chk("reach_byte3", cb[0], 2);
        @(negedge clk);
        monitor();
        reset = 1'b1;
        drive();
        #1;
        chk("drdy_in_reset", p_drdy, 0);
        @(negedge clk);
        chk("abort_dv", rx_dv, 0);
        chk("abort_grant", grant, 0);
        chk("abort_rxd", rxd, 8'h00);
        reset = 1'b0;
        #1;
        chk("abort_drdy", p_drdy, 0);
        for (int i = 0; i < N; i++) begin dq[i].delete(); mq[i].delete(); cb[i] = 0; cg[i] = 0; end
        in_frame = 0; seen_frame = 0; gap_chk = 0; last_rr = N - 1;

        set_pkt(base + 1, 2);
        set_pkt(base + 2, 2);
        load(0, base + 1);
        load(1, base + 2);
        target = frames + 2;
        cyc = 0;
        while (frames < target && cyc < 500) begin step(); cyc++; end
        chk("post_reset_frames", frames, target);
        repeat (IFG + 2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
